prbs_burst_ctrl: RTL and testbench
==================================

// Module: prbs_burst_ctrl
// PURPOSE
//  Sequences the 31-bit XNOR PRBS generator (x^31+x^28) for bursts of test data.
//  On a start pulse it enables the generator and discards a warm-up prefix.
//  It packs the serial bit stream into WORD_W-bit words behind a 2-entry output FIFO
//  with a valid/ready handshake, then stops the generator and pulses done.
//  The generator clears whenever its enable is low, so every burst replays the same sequence.
// PARAMETERS
//  WORD_W   8   bits per output word (>=2)
//  CNT_W    16  width of num_words and of the internal word counter
//  WARMUP   24  generator bits discarded before the first word (0..255)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active low
//  start       in   1       1-cycle burst request; honoured only in IDLE
//  abort       in   1       terminate the burst immediately, any state
//  num_words   in   CNT_W   words per burst, sampled when start is accepted
//  lfsr_en     out  1       generator shift enable (registered)
//  lfsr_data   in   1       generator serial output
//  word_data   out  WORD_W  FIFO head word; first generated bit is in the MSB
//  word_valid  out  1       FIFO non-empty
//  word_ready  in   1       consumer accepts word_data when word_valid && word_ready
//  busy        out  1       high in WARM/RUN/DRAIN
//  done        out  1       1-cycle pulse at normal burst completion
//  overrun     out  1       sticky: a word was dropped on a full FIFO; cleared on accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFO empty; counters and shifter 0.
//  States: IDLE -> WARM -> RUN -> DRAIN -> IDLE.
//   IDLE: accepted start with num_words!=0 -> WARM, or -> RUN if WARMUP==0; lfsr_en=1 from the next cycle.
//   IDLE: start with num_words==0 -> done pulses the next cycle; lfsr_en stays 0.
//   WARM: lasts until WARMUP bits are captured and discarded; then -> RUN.
//   RUN: lfsr_en is held gapless high for exactly WARMUP+WORD_W*num_words enabled edges, then drops.
//   RUN -> DRAIN when the last word is written or dropped.
//   DRAIN: waits for the FIFO to empty; then done=1 for one cycle -> IDLE.
//  Capture: the generator shifts on each edge with lfsr_en=1.
//   The controller samples lfsr_data one edge later: it captures whenever lfsr_en was high
//   in the previous cycle (a delayed-enable flag).
//  Packing: the capture shifter shifts left and inserts at the LSB.
//   After WORD_W captures the word is pushed, so the first captured bit ends up in the MSB.
//  FIFO: depth 2; a push and a pop in the same cycle are allowed when the FIFO is full.
//   A word that completes while the FIFO is full and no pop occurs is dropped.
//   A dropped word sets overrun and still counts toward num_words.
//  Handshake: word_data and word_valid are stable until accepted; word_valid does not depend
//   combinationally on word_ready.
//  abort (any state, priority over start): next cycle lfsr_en=0, FIFO flushed, word_valid=0,
//   state IDLE, no done pulse, overrun kept.
//  start while busy: ignored. Async reset mid-burst: immediate return to the reset state.
//  After every burst lfsr_en is low for >=1 cycle, so the next burst starts from the cleared generator.
// TESTING
//  WARMUP=0, WORD_W=8, num_words=1, ready=1 -> one word 0xFF; lfsr_en high for exactly 8 cycles;
//   done follows.
//  WARMUP=24, num_words=1 -> word 0xF1 (generator bits 25..32 = 1111_0001).
//  WARMUP=0, num_words=4, ready=0 until done would fire -> words 3 and 4 dropped; overrun=1.
//   Then 2 words popped (0xFF, 0xFF), then done.
//  Run the same burst twice back-to-back -> identical word sequences; overrun cleared by the 2nd start.
//  abort two cycles into RUN -> lfsr_en=0 and word_valid=0 next cycle; no done; a new start is accepted.
//  start with num_words=0 -> done pulse, lfsr_en never rises; start during busy -> no effect.

Source files
------------

// File: rtl/prbs_burst_ctrl.sv
// Power-of-two deep synchronous FIFO; a push on a full cycle is taken only alongside a pop.
// Latency: a pushed entry appears at pop_dat the cycle after the push.
// Backpressure: push_rdy low when full with no pop; flush empties it in one cycle.
module pbc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign pop_vld  = (count != '0);
  assign pop      = pop_vld && pop_rdy;
  assign push_rdy = (count != (AW+1)'(DEPTH)) || pop;
  assign push     = push_vld && push_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// Burst sequencer for an external 31-bit XNOR PRBS: warm-up discard, word packing, 2-deep output FIFO.
// Latency: lfsr_en rises the cycle after start; first word is visible WARMUP+WORD_W+2 cycles after start.
// Backpressure: words completing on a full FIFO with no pop are dropped and flag overrun; the generator never stalls.
module prbs_burst_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16,
  parameter int WARMUP = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_words,
  output logic              lfsr_en,
  input  logic              lfsr_data,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int PROD_W = CNT_W + BIT_W;
  localparam int TOT_W  = ((PROD_W > 8) ? PROD_W : 8) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              cap_en;
  logic [TOT_W-1:0]  issue_cnt;
  logic [7:0]        warm_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  word_cnt, num_q;
  logic [WORD_W-1:0] shift_q, word_next;
  logic              start_ok, word_done, last_word, push_vld, push_rdy;

  assign start_ok  = start && !abort && (state_q == S_IDLE);
  assign word_next = {shift_q[WORD_W-2:0], lfsr_data};
  assign word_done = (state_q == S_RUN) && cap_en && (bit_cnt == BIT_W'(WORD_W - 1));
  assign last_word = word_done && (word_cnt == num_q - CNT_W'(1));
  assign push_vld  = word_done && !abort;
  assign busy      = (state_q != S_IDLE);

  pbc_fifo #(.W(WORD_W), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push_vld (push_vld),
    .push_dat (word_next),
    .push_rdy (push_rdy),
    .pop_vld  (word_valid),
    .pop_dat  (word_data),
    .pop_rdy  (word_ready)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok && num_words != '0) state_d = (WARMUP == 0) ? S_RUN : S_WARM;
      S_WARM:  if (cap_en && warm_cnt == 8'(WARMUP - 1)) state_d = S_RUN;
      S_RUN:   if (last_word) state_d = S_DRAIN;
      S_DRAIN: if (!word_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lfsr_en   <= 1'b0;
      cap_en    <= 1'b0;
      issue_cnt <= '0;
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      num_q     <= '0;
      shift_q   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= !abort && (((state_q == S_DRAIN) && !word_valid) || (start_ok && num_words == '0));
      // The generator output lags its enable by one edge, so capture follows a delayed copy.
      cap_en  <= lfsr_en && !abort;

      // issue_cnt holds the enabled edges still owed, including the current cycle's.
      if (abort) begin
        lfsr_en   <= 1'b0;
        issue_cnt <= '0;
      end else if (start_ok && num_words != '0) begin
        lfsr_en   <= 1'b1;
        issue_cnt <= TOT_W'(WARMUP) + TOT_W'(num_words) * TOT_W'(WORD_W);
      end else if (lfsr_en) begin
        lfsr_en   <= (issue_cnt != TOT_W'(1));
        issue_cnt <= issue_cnt - TOT_W'(1);
      end

      if (start_ok) begin
        num_q    <= num_words;
        overrun  <= 1'b0;
        warm_cnt <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else if (push_vld && !push_rdy) begin
        overrun <= 1'b1;
      end

      if (cap_en && state_q == S_WARM) warm_cnt <= warm_cnt + 8'd1;
      if (cap_en && state_q == S_RUN) begin
        shift_q <= word_next;
        bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
        if (word_done) word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: two instances (WARMUP 0 and 24) each driving a behavioural PRBS generator.
module tb_prbs_burst_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst, sel, start_i, abort_i, ready_i;
  logic [CNT_W-1:0] num_i;

  logic d0_start, d0_abort, d0_ready, d0_en, d0_data, d0_valid, d0_busy, d0_done, d0_ovr;
  logic d1_start, d1_abort, d1_ready, d1_en, d1_data, d1_valid, d1_busy, d1_done, d1_ovr;
  logic [7:0] d0_word, d1_word;
  logic [30:0] g0, g1;

  logic o_en, o_valid, o_busy, o_done, o_ovr;
  logic [7:0] o_word;

  int checks = 0;
  int errors = 0;
  bit prbs [0:511];

  logic [7:0] got_q [$];
  int en_cycles, en_rises, done_cnt;
  logic prev_en;

  always #5 clk = ~clk;

  assign d0_start = start_i & ~sel;
  assign d1_start = start_i & sel;
  assign d0_abort = abort_i & ~sel;
  assign d1_abort = abort_i & sel;
  assign d0_ready = sel ? 1'b1 : ready_i;
  assign d1_ready = sel ? ready_i : 1'b1;
  assign d0_data  = g0[0];
  assign d1_data  = g1[0];
  assign o_en     = sel ? d1_en    : d0_en;
  assign o_valid  = sel ? d1_valid : d0_valid;
  assign o_busy   = sel ? d1_busy  : d0_busy;
  assign o_done   = sel ? d1_done  : d0_done;
  assign o_ovr    = sel ? d1_ovr   : d0_ovr;
  assign o_word   = sel ? d1_word  : d0_word;

  prbs_burst_ctrl #(.WORD_W(8), .CNT_W(CNT_W), .WARMUP(0)) dut0 (
    .clk(clk), .rst(rst), .start(d0_start), .abort(d0_abort), .num_words(num_i),
    .lfsr_en(d0_en), .lfsr_data(d0_data), .word_data(d0_word), .word_valid(d0_valid),
    .word_ready(d0_ready), .busy(d0_busy), .done(d0_done), .overrun(d0_ovr));

  prbs_burst_ctrl #(.WORD_W(8), .CNT_W(CNT_W), .WARMUP(24)) dut24 (
    .clk(clk), .rst(rst), .start(d1_start), .abort(d1_abort), .num_words(num_i),
    .lfsr_en(d1_en), .lfsr_data(d1_data), .word_data(d1_word), .word_valid(d1_valid),
    .word_ready(d1_ready), .busy(d1_busy), .done(d1_done), .overrun(d1_ovr));

  // External generator: shifts while enabled, cleared whenever the enable is low.
  always @(posedge clk or negedge rst) begin
    if (!rst) g0 <= '0;
    else if (!d0_en) g0 <= '0;
    else g0 <= {g0[29:0], ~(g0[30] ^ g0[27])};
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) g1 <= '0;
    else if (!d1_en) g1 <= '0;
    else g1 <= {g1[29:0], ~(g1[30] ^ g1[27])};
  end

  always @(negedge clk) begin
    if (rst) begin
      if (o_valid && ready_i) got_q.push_back(o_word);
      if (o_en) en_cycles++;
      if (o_en && !prev_en) en_rises++;
      prev_en = o_en;
      if (o_done) done_cnt++;
    end
  end

  function automatic logic [7:0] exp_word(input int warm, input int k);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[7-i] = prbs[warm + 8*k + 1 + i];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    en_cycles = 0;
    en_rises  = 0;
    done_cnt  = 0;
    prev_en   = o_en;
  endtask

  task automatic pulse_start(input int n);
    clear_mon();
    num_i   = CNT_W'(n);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Must be entered just after a rising edge so ready only changes there.
  task automatic wait_done(input int pct, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      ready_i = ($urandom_range(0, 99) < pct);
      sample();
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    ready_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({d0_en, d0_valid, d0_busy, d0_done, d0_ovr} !== 5'b0) begin errors++; $display("FAIL reset_ctl0 got %b exp 00000", {d0_en, d0_valid, d0_busy, d0_done, d0_ovr}); end
    checks++; if ({d1_en, d1_valid, d1_busy, d1_done, d1_ovr} !== 5'b0) begin errors++; $display("FAIL reset_ctl24 got %b exp 00000", {d1_en, d1_valid, d1_busy, d1_done, d1_ovr}); end
    rst = 1'b1;
    tick();
    sample();
    checks++; if (d0_word !== 8'h00) begin errors++; $display("FAIL reset_word0 got %h exp 00", d0_word); end
    checks++; if ({d1_en, d1_valid, d1_busy, d1_done, d1_ovr, d1_word} !== 13'b0) begin errors++; $display("FAIL post_reset24 got %h exp 0", {d1_en, d1_valid, d1_busy, d1_done, d1_ovr, d1_word}); end
    tick();
  endtask

  task automatic test_single_word();
    bit to;
    sel = 1'b0;
    pulse_start(1);
    wait_done(100, 40, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got timeout exp done"); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hFF) begin errors++; $display("FAIL single_word got %h exp ff", got_q[0]); end
    end
    checks++; if (en_cycles !== 8 || en_rises !== 1) begin errors++; $display("FAIL single_en got %0d/%0d exp 8/1", en_cycles, en_rises); end
    checks++; if (done_cnt !== 1 || o_ovr !== 1'b0) begin errors++; $display("FAIL single_done got %0d ovr %b exp 1 ovr 0", done_cnt, o_ovr); end
    tick();
  endtask

  task automatic test_warmup();
    bit to;
    sel = 1'b1;
    pulse_start(1);
    wait_done(100, 80, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL warm_timeout got timeout exp done"); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL warm_count got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hF1) begin errors++; $display("FAIL warm_word got %h exp f1", got_q[0]); end
    end
    checks++; if (en_cycles !== 32) begin errors++; $display("FAIL warm_en got %0d exp 32", en_cycles); end
    tick();
  endtask

  task automatic test_overrun();
    bit to;
    sel = 1'b0;
    ready_i = 1'b0;
    pulse_start(4);
    repeat (45) tick();
    sample();
    checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", o_ovr); end
    checks++; if (done_cnt !== 0 || o_valid !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL ovr_hold got done %0d vld %b busy %b exp 0 1 1", done_cnt, o_valid, o_busy); end
    checks++; if (en_cycles !== 32) begin errors++; $display("FAIL ovr_en got %0d exp 32", en_cycles); end
    tick();
    wait_done(100, 20, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovr_timeout got timeout exp done"); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL ovr_count got %0d exp 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hFF || got_q[1] !== 8'hFF) begin errors++; $display("FAIL ovr_words got %h %h exp ff ff", got_q[0], got_q[1]); end
    end
    checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", o_ovr); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [7:0] qa [$];
    sel = 1'b0;
    pulse_start(5);
    sample();
    checks++; if (o_ovr !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL b2b_clear got ovr %b busy %b exp 0 1", o_ovr, o_busy); end
    tick();
    wait_done(100, 80, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout_a got timeout exp done"); end
    qa = got_q;
    pulse_start(5);
    wait_done(100, 80, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout_b got timeout exp done"); end
    checks++; if (qa.size() !== 5 || got_q.size() !== 5) begin errors++; $display("FAIL b2b_count got %0d %0d exp 5 5", qa.size(), got_q.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (got_q[k] !== qa[k]) begin errors++; $display("FAIL b2b_repeat[%0d] got %h exp %h", k, got_q[k], qa[k]); end
        checks++; if (qa[k] !== exp_word(0, k)) begin errors++; $display("FAIL b2b_model[%0d] got %h exp %h", k, qa[k], exp_word(0, k)); end
      end
    end
    tick();
  endtask

  task automatic test_abort();
    bit to;
    sel = 1'b0;
    ready_i = 1'b0;
    pulse_start(4);
    repeat (28) tick();
    sample();
    checks++; if (o_ovr !== 1'b1 || o_valid !== 1'b1) begin errors++; $display("FAIL abort_pre got ovr %b vld %b exp 1 1", o_ovr, o_valid); end
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    sample();
    checks++; if ({o_en, o_valid, o_busy, o_ovr} !== 4'b0001) begin errors++; $display("FAIL abort_fifo got %b exp 0001", {o_en, o_valid, o_busy, o_ovr}); end
    repeat (20) tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_nodone0 got %0d exp 0", done_cnt); end
    sel = 1'b1;
    pulse_start(3);
    repeat (26) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    sample();
    checks++; if ({o_en, o_valid, o_busy} !== 3'b000) begin errors++; $display("FAIL abort_run got %b exp 000", {o_en, o_valid, o_busy}); end
    tick();
    repeat (20) tick();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_nodone24 got %0d exp 0", done_cnt); end
    ready_i = 1'b1;
    pulse_start(1);
    wait_done(100, 80, to);
    checks++; if (to !== 1'b0 || got_q.size() !== 1) begin errors++; $display("FAIL abort_restart got to %b n %0d exp 0 1", to, got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hF1) begin errors++; $display("FAIL abort_replay got %h exp f1", got_q[0]); end
    end
    tick();
  endtask

  task automatic test_zero_words();
    sel = 1'b0;
    pulse_start(0);
    sample();
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_done got done %b busy %b exp 1 0", o_done, o_busy); end
    tick();
    repeat (10) tick();
    checks++; if (en_rises !== 0 || done_cnt !== 1) begin errors++; $display("FAIL zero_quiet got rises %0d done %0d exp 0 1", en_rises, done_cnt); end
  endtask

  task automatic test_start_busy();
    bit to;
    sel = 1'b0;
    pulse_start(2);
    for (int i = 0; i < 4; i++) begin
      num_i = CNT_W'(7);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
    end
    wait_done(100, 60, to);
    tick();
    repeat (10) tick();
    checks++; if (to !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL busy_done got to %b done %0d exp 0 1", to, done_cnt); end
    checks++; if (en_cycles !== 16 || en_rises !== 1) begin errors++; $display("FAIL busy_en got %0d/%0d exp 16/1", en_cycles, en_rises); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL busy_count got %0d exp 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_word(0, 0) || got_q[1] !== exp_word(0, 1)) begin errors++; $display("FAIL busy_words got %h %h exp %h %h", got_q[0], got_q[1], exp_word(0, 0), exp_word(0, 1)); end
    end
  endtask

  task automatic test_random();
    bit to, have_prev, prev_v, prev_r, ok;
    logic [7:0] prev_w;
    int n, pct, warm, idx;
    for (int it = 0; it < 10; it++) begin
      sel  = 1'($urandom_range(0, 1));
      warm = sel ? 24 : 0;
      n    = $urandom_range(1, 6);
      pct  = $urandom_range(15, 100);
      pulse_start(n);
      to = 1'b1;
      have_prev = 1'b0;
      for (int c = 0; c < 600; c++) begin
        ready_i = ($urandom_range(0, 99) < pct);
        sample();
        if (have_prev && prev_v && !prev_r) begin
          checks++; if (o_valid !== 1'b1 || o_word !== prev_w) begin errors++; $display("FAIL rnd_hold got %b %h exp 1 %h", o_valid, o_word, prev_w); end
        end
        prev_v = o_valid; prev_r = ready_i; prev_w = o_word; have_prev = 1'b1;
        if (done_cnt > 0) begin
          to = 1'b0;
          break;
        end
        tick();
      end
      ready_i = 1'b1;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd_timeout it %0d got timeout exp done", it); end
      checks++; if (en_cycles !== warm + 8*n || en_rises !== 1) begin errors++; $display("FAIL rnd_en it %0d got %0d/%0d exp %0d/1", it, en_cycles, en_rises, warm + 8*n); end
      ok = (got_q.size() <= n);
      idx = 0;
      foreach (got_q[j]) begin
        while (idx < n && exp_word(warm, idx) !== got_q[j]) idx++;
        if (idx >= n) ok = 1'b0;
        idx++;
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_order it %0d got %0d words not in model order", it, got_q.size()); end
      checks++; if (o_ovr !== (got_q.size() < n)) begin errors++; $display("FAIL rnd_ovr it %0d got %b exp %b", it, o_ovr, got_q.size() < n); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    bit to;
    sel = 1'b0;
    pulse_start(3);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    checks++; if ({d0_en, d0_valid, d0_busy, d0_done, d0_ovr} !== 5'b0) begin errors++; $display("FAIL areset got %b exp 00000", {d0_en, d0_valid, d0_busy, d0_done, d0_ovr}); end
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    pulse_start(1);
    wait_done(100, 40, to);
    checks++; if (to !== 1'b0 || got_q.size() !== 1) begin errors++; $display("FAIL areset_burst got to %b n %0d exp 0 1", to, got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hFF || en_cycles !== 8) begin errors++; $display("FAIL areset_word got %h en %0d exp ff 8", got_q[0], en_cycles); end
    end
    tick();
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1; num_i = '0;
    for (int n = 1; n < 512; n++)
      prbs[n] = ~(((n > 31) ? prbs[n-31] : 1'b0) ^ ((n > 28) ? prbs[n-28] : 1'b0));
    prbs[0] = 1'b0;
    clear_mon();
    test_reset();
    test_single_word();
    test_warmup();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_zero_words();
    test_start_busy();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
